// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map and FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

   // Opcode map, compatible with the original 4-bit combinational ALU
   localparam logic [3:0] OP_ADDC   = 4'b0001;
   localparam logic [3:0] OP_ADD    = 4'b0010;
   localparam logic [3:0] OP_SUB    = 4'b0011;
   localparam logic [3:0] OP_AND    = 4'b0100;
   localparam logic [3:0] OP_NOR    = 4'b0101;
   localparam logic [3:0] OP_XNOR   = 4'b0110;
   localparam logic [3:0] OP_NOT    = 4'b0111;
   localparam logic [3:0] OP_LSR    = 4'b1000;
   localparam logic [3:0] OP_LSL    = 4'b1001;
   localparam logic [3:0] OP_ASR    = 4'b1010;
   localparam logic [3:0] OP_ACC    = 4'b1011;
   localparam logic [3:0] OP_CLRACC = 4'b1100;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor shared by ADD, ADDC, SUB and ACC.
// Latency: purely combinational.
// Backpressure: none.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of
);

   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [WIDTH:0]   full;

   // Subtract is A + ~B + 1, so carry-out doubles as the no-borrow flag
   always_comb begin
      b_eff = sub ? ~b : b;
      c_eff = sub ? 1'b1 : cin;
      full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
      sum   = full[WIDTH-1:0];
      cout  = full[WIDTH];
      // Overflow: both addends share a sign that the result does not
      of    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
   end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with accumulator, iterative shifts and zero/neg flags.
// Latency: 1 cycle for arithmetic/logic, max(k,1) cycles for a k-bit shift.
// Backpressure: none; start is ignored while a shift is busy (no queueing).
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] aluin_a,
   input  logic [WIDTH-1:0] aluin_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] alu_out,
   output logic             cout,
   output logic             of,
   output logic             zero,
   output logic             neg
);

   localparam logic [WIDTH-1:0] W_B = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    W_C = CW'(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [3:0]       op_q, op_nxt;
   logic [WIDTH-1:0] alu_out_nxt;
   logic             cout_nxt, of_nxt, done_nxt;

   logic [WIDTH-1:0] as_a, as_b, as_sum;
   logic             as_cin, as_sub, as_cout, as_of;
   logic [CW-1:0]    k;
   logic [WIDTH:0]   sh_start, sh_run;

   // One-bit shift step; MSB of the return value is the bit shifted out
   function automatic logic [WIDTH:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] v);
      logic [WIDTH:0] r;
      r = {1'b0, v};
      case (op)
         OP_LSR:  r = {v[0], 1'b0, v[WIDTH-1:1]};
         OP_LSL:  r = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OP_ASR:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
         default: r = {1'b0, v};
      endcase
      return r;
   endfunction

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a    (as_a),
      .b    (as_b),
      .cin  (as_cin),
      .sub  (as_sub),
      .sum  (as_sum),
      .cout (as_cout),
      .of   (as_of)
   );

   assign busy = (state == ST_SHIFT);
   assign zero = (alu_out == '0);
   assign neg  = alu_out[WIDTH-1];

   // Next-state, datapath muxing and result selection
   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      shreg_nxt   = shreg;
      cnt_nxt     = cnt;
      op_nxt      = op_q;
      alu_out_nxt = alu_out;
      cout_nxt    = cout;
      of_nxt      = of;
      done_nxt    = 1'b0;

      // Adder operands: ACC adds A into the accumulator, others use A/B
      as_a   = (opcode == OP_ACC) ? acc : aluin_a;
      as_b   = (opcode == OP_ACC) ? aluin_a : aluin_b;
      as_cin = (opcode == OP_ADDC) ? cin : 1'b0;
      as_sub = (opcode == OP_SUB);

      // Shift distance saturates at WIDTH
      k        = (aluin_b > W_B) ? W_C : aluin_b[CW-1:0];
      sh_start = shift1(opcode, aluin_a);
      sh_run   = shift1(op_q, shreg);

      case (state)
         ST_IDLE: begin
            if (start) begin
               done_nxt = 1'b1;
               cout_nxt = 1'b0;
               of_nxt   = 1'b0;
               case (opcode)
                  OP_ADDC, OP_ADD, OP_SUB: begin
                     alu_out_nxt = as_sum;
                     cout_nxt    = as_cout;
                     of_nxt      = as_of;
                  end
                  OP_ACC: begin
                     acc_nxt     = as_sum;
                     alu_out_nxt = as_sum;
                     cout_nxt    = as_cout;
                     of_nxt      = as_of;
                  end
                  OP_CLRACC: begin
                     acc_nxt     = '0;
                     alu_out_nxt = '0;
                  end
                  OP_AND:  alu_out_nxt = aluin_a & aluin_b;
                  OP_NOR:  alu_out_nxt = ~(aluin_a | aluin_b);
                  OP_XNOR: alu_out_nxt = ~(aluin_a ^ aluin_b);
                  OP_NOT:  alu_out_nxt = ~aluin_a;
                  OP_LSR, OP_LSL, OP_ASR: begin
                     if (k == '0) begin
                        alu_out_nxt = aluin_a;
                     end else if (k == CW'(1)) begin
                        alu_out_nxt = sh_start[WIDTH-1:0];
                        cout_nxt    = sh_start[WIDTH];
                     end else begin
                        // First bit shifts now; the rest iterate in ST_SHIFT
                        done_nxt  = 1'b0;
                        cout_nxt  = cout;
                        of_nxt    = of;
                        shreg_nxt = sh_start[WIDTH-1:0];
                        cnt_nxt   = k - CW'(1);
                        op_nxt    = opcode;
                        state_nxt = ST_SHIFT;
                     end
                  end
                  default: alu_out_nxt = '0;
               endcase
            end
         end
         ST_SHIFT: begin
            shreg_nxt = sh_run[WIDTH-1:0];
            cnt_nxt   = cnt - CW'(1);
            // Last remaining bit: publish result and the bit it pushed out
            if (cnt == CW'(1)) begin
               done_nxt    = 1'b1;
               alu_out_nxt = sh_run[WIDTH-1:0];
               cout_nxt    = sh_run[WIDTH];
               of_nxt      = 1'b0;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and result registers; reset aborts any shift in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         acc     <= '0;
         shreg   <= '0;
         cnt     <= '0;
         op_q    <= 4'b0000;
         alu_out <= '0;
         cout    <= 1'b0;
         of      <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         shreg   <= shreg_nxt;
         cnt     <= cnt_nxt;
         op_q    <= op_nxt;
         alu_out <= alu_out_nxt;
         cout    <= cout_nxt;
         of      <= of_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) against an arithmetic reference model.
// Latency: checks 1-cycle ops and max(k,1)-cycle shifts.
// Backpressure: checks that start during a shift is dropped.
module tb_alu_seq;

   localparam logic [3:0] T_ADDC = 4'd1, T_ADD = 4'd2, T_SUB = 4'd3, T_AND = 4'd4;
   localparam logic [3:0] T_NOR = 4'd5, T_XNOR = 4'd6, T_NOT = 4'd7, T_LSR = 4'd8;
   localparam logic [3:0] T_LSL = 4'd9, T_ASR = 4'd10, T_ACC = 4'd11, T_CLR = 4'd12;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] opcode;
   logic [7:0] aluin_a, aluin_b;
   logic       cin;
   logic       busy, done, cout, of, zero, neg;
   logic [7:0] alu_out;

   int vec_cnt = 0;
   int err_cnt = 0;
   int model_acc = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .opcode  (opcode),
      .aluin_a (aluin_a),
      .aluin_b (aluin_b),
      .cin     (cin),
      .busy    (busy),
      .done    (done),
      .alu_out (alu_out),
      .cout    (cout),
      .of      (of),
      .zero    (zero),
      .neg     (neg)
   );

   function automatic int sx(input int v);
      return (v >= 128) ? v - 256 : v;
   endfunction

   // Reference model: plain integer arithmetic from the opcode definitions
   task automatic model(input int op, input int a, input int b, input int ci,
                        output int res, output int c, output int o, output int lat);
      int s, k, sa;
      res = 0; c = 0; o = 0; lat = 1;
      case (op)
         1, 2: begin
            s = a + b + ((op == 1) ? ci : 0);
            res = s & 255; c = s >> 8;
            s = sx(a) + sx(b) + ((op == 1) ? ci : 0);
            o = (s > 127 || s < -128) ? 1 : 0;
         end
         3: begin
            res = (a - b) & 255; c = (a >= b) ? 1 : 0;
            s = sx(a) - sx(b);
            o = (s > 127 || s < -128) ? 1 : 0;
         end
         4: res = a & b;
         5: res = ~(a | b) & 255;
         6: res = ~(a ^ b) & 255;
         7: res = ~a & 255;
         8, 9, 10: begin
            k = (b > 8) ? 8 : b;
            lat = (k > 1) ? k : 1;
            sa = sx(a);
            if (k == 0) res = a;
            else if (op == 8) begin res = a >> k; c = (a >> (k - 1)) & 1; end
            else if (op == 9) begin res = (a << k) & 255; c = (a >> (8 - k)) & 1; end
            else begin res = (sa >>> k) & 255; c = (sa >>> (k - 1)) & 1; end
         end
         11: begin
            s = model_acc + a;
            res = s & 255; c = s >> 8;
            s = sx(model_acc) + sx(a);
            o = (s > 127 || s < -128) ? 1 : 0;
            model_acc = res;
         end
         12: model_acc = 0;
         default: res = 0;
      endcase
   endtask

   // Issue one start (called between edges) and wait, bounded, for done
   task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, output int lat, output int busy_err);
      opcode = op; aluin_a = a; aluin_b = b; cin = ci; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1; busy_err = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_err++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy !== 1'b0) busy_err++;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; opcode = 4'd0; aluin_a = 8'd0; aluin_b = 8'd0; cin = 1'b0;
      #12;
      vec_cnt++;
      if ({busy, done, alu_out, cout, of, zero, neg} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         err_cnt++;
         $display("FAIL reset_state: got busy=%b done=%b out=%h cout=%b of=%b zero=%b neg=%b, expected 0 0 00 0 0 1 0",
                  busy, done, alu_out, cout, of, zero, neg);
      end
      reset = 1'b0;
   endtask

   task automatic test_add_sub;
      int lat, be;
      do_op(T_ADD, 8'h7F, 8'h01, 1'b0, lat, be);
      vec_cnt++;
      if ({lat == 1, be == 0} !== 2'b11) begin
         err_cnt++; $display("FAIL add_timing: got lat=%0d busy_err=%0d, expected lat=1 busy_err=0", lat, be);
      end
      vec_cnt++;
      if ({alu_out, of, cout, neg, zero} !== {8'h80, 1'b1, 1'b0, 1'b1, 1'b0}) begin
         err_cnt++; $display("FAIL add_7f_01: got out=%h of=%b cout=%b neg=%b zero=%b, expected 80 1 0 1 0", alu_out, of, cout, neg, zero);
      end
      do_op(T_SUB, 8'h05, 8'h07, 1'b0, lat, be);
      vec_cnt++;
      if ({alu_out, cout, of, neg} !== {8'hFE, 1'b0, 1'b0, 1'b1}) begin
         err_cnt++; $display("FAIL sub_borrow: got out=%h cout=%b of=%b neg=%b, expected fe 0 0 1", alu_out, cout, of, neg);
      end
      do_op(T_SUB, 8'h07, 8'h07, 1'b0, lat, be);
      vec_cnt++;
      if ({alu_out, cout, zero} !== {8'h00, 1'b1, 1'b1}) begin
         err_cnt++; $display("FAIL sub_equal: got out=%h cout=%b zero=%b, expected 00 1 1", alu_out, cout, zero);
      end
   endtask

   task automatic test_shift;
      int lat, be;
      opcode = T_LSR; aluin_a = 8'h0E; aluin_b = 8'd2; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      vec_cnt++;
      if ({busy, done} !== 2'b10) begin
         err_cnt++; $display("FAIL lsr_busy: got busy=%b done=%b, expected 1 0", busy, done);
      end
      opcode = T_ADD; aluin_a = 8'h01; aluin_b = 8'h01;
      @(posedge clk); #1;
      start = 1'b0;
      vec_cnt++;
      if ({done, busy, alu_out, cout} !== {1'b1, 1'b0, 8'h03, 1'b1}) begin
         err_cnt++; $display("FAIL lsr_result: got done=%b busy=%b out=%h cout=%b, expected 1 0 03 1", done, busy, alu_out, cout);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if ({done, alu_out} !== {1'b0, 8'h03}) begin
         err_cnt++; $display("FAIL start_ignored: got done=%b out=%h, expected 0 03", done, alu_out);
      end
      do_op(T_ASR, 8'h90, 8'd12, 1'b0, lat, be);
      vec_cnt++;
      if ({lat == 8, be == 0, alu_out, cout} !== {1'b1, 1'b1, 8'hFF, 1'b1}) begin
         err_cnt++; $display("FAIL asr_clamp: got lat=%0d busy_err=%0d out=%h cout=%b, expected 8 0 ff 1", lat, be, alu_out, cout);
      end
      do_op(T_LSL, 8'h5A, 8'd0, 1'b0, lat, be);
      vec_cnt++;
      if ({lat == 1, alu_out, cout} !== {1'b1, 8'h5A, 1'b0}) begin
         err_cnt++; $display("FAIL lsl_zero: got lat=%0d out=%h cout=%b, expected 1 5a 0", lat, alu_out, cout);
      end
   endtask

   task automatic test_acc;
      int lat, be;
      logic [7:0] exp_out [3] = '{8'h60, 8'hC0, 8'h20};
      logic [1:0] exp_co  [3] = '{2'b00, 2'b01, 2'b10};
      do_op(T_CLR, 8'h00, 8'h00, 1'b0, lat, be);
      for (int i = 0; i < 3; i++) begin
         do_op(T_ACC, 8'h60, 8'h00, 1'b0, lat, be);
         vec_cnt++;
         if ({alu_out, cout, of} !== {exp_out[i], exp_co[i]}) begin
            err_cnt++; $display("FAIL acc_step%0d: got out=%h cout=%b of=%b, expected %h %b", i, alu_out, cout, of, exp_out[i], exp_co[i]);
         end
      end
      do_op(T_CLR, 8'h00, 8'h00, 1'b0, lat, be);
      vec_cnt++;
      if ({alu_out, zero} !== {8'h00, 1'b1}) begin
         err_cnt++; $display("FAIL clracc: got out=%h zero=%b, expected 00 1", alu_out, zero);
      end
   endtask

   task automatic test_reset_mid_shift;
      int lat, be;
      opcode = T_LSR; aluin_a = 8'hF0; aluin_b = 8'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      vec_cnt++;
      if (busy !== 1'b1) begin
         err_cnt++; $display("FAIL mid_shift_busy: got busy=%b, expected 1", busy);
      end
      reset = 1'b1;
      #1;
      vec_cnt++;
      if ({busy, done, alu_out, zero} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
         err_cnt++; $display("FAIL reset_abort: got busy=%b done=%b out=%h zero=%b, expected 0 0 00 1", busy, done, alu_out, zero);
      end
      #2;
      reset = 1'b0;
      do_op(T_ADD, 8'h01, 8'h01, 1'b0, lat, be);
      vec_cnt++;
      if ({lat == 1, alu_out} !== {1'b1, 8'h02}) begin
         err_cnt++; $display("FAIL add_after_reset: got lat=%0d out=%h, expected 1 02", lat, alu_out);
      end
   endtask

   task automatic test_random;
      int lat, be, e_res, e_c, e_o, e_lat;
      logic [3:0] op;
      logic [7:0] a, b;
      logic ci;
      do_op(T_CLR, 8'h00, 8'h00, 1'b0, lat, be);
      model_acc = 0;
      for (int i = 0; i < 120; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom);
         b  = (op >= T_LSR && op <= T_ASR) ? 8'($urandom_range(0, 12)) : 8'($urandom);
         ci = 1'($urandom_range(0, 1));
         model(int'(op), int'(a), int'(b), int'(ci), e_res, e_c, e_o, e_lat);
         do_op(op, a, b, ci, lat, be);
         vec_cnt++;
         if (lat != e_lat || be != 0) begin
            err_cnt++; $display("FAIL rnd%0d_timing op=%0d b=%0d: got lat=%0d busy_err=%0d, expected lat=%0d busy_err=0", i, op, b, lat, be, e_lat);
         end
         vec_cnt++;
         if (alu_out !== 8'(e_res)) begin
            err_cnt++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h, expected %h", i, op, a, b, alu_out, 8'(e_res));
         end
         vec_cnt++;
         if ({cout, of} !== {1'(e_c), 1'(e_o)}) begin
            err_cnt++; $display("FAIL rnd%0d_flags op=%0d a=%h b=%h: got cout=%b of=%b, expected %0d %0d", i, op, a, b, cout, of, e_c, e_o);
         end
         vec_cnt++;
         if ({zero, neg} !== {e_res == 0, e_res >= 128}) begin
            err_cnt++; $display("FAIL rnd%0d_zn: got zero=%b neg=%b for result %h", i, zero, neg, 8'(e_res));
         end
      end
   endtask

   initial begin
      test_reset;
      test_add_sub;
      test_shift;
      test_acc;
      test_reset_mid_shift;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- WIDTH-bit datapath with the same opcode map (add with/without carry-in, subtract, AND, NOR, XNOR, NOT, logical shift right), plus variable-distance iterative shifts, an internal accumulator and zero/negative flags.
- Start/done handshake, so it can sit behind the seven-segment/register-file datapath as a multi-cycle execution unit.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CW, $clog2(WIDTH+1), width of the internal shift counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- opcode  in  4  operation select, captured on accepted start.
- aluin_a  in  WIDTH  operand A, captured on accepted start.
- aluin_b  in  WIDTH  operand B (shift distance for shift ops), captured on accepted start.
- cin  in  1  carry-in for ADDC, captured on accepted start.
- busy  out  1  high while an iterative shift is in progress.
- done  out  1  one-cycle pulse: result/flags updated this cycle.
- alu_out  out  WIDTH  registered result, held until the next done.
- cout  out  1  carry / no-borrow / last bit shifted out.
- of  out  1  signed overflow.
- zero  out  1  alu_out == 0.
- neg  out  1  alu_out[WIDTH-1].

Behaviour:
- Reset (async, active-high): state IDLE, busy=0, done=0, alu_out=0, cout=0, of=0, zero=1, neg=0, accumulator=0, shift counter=0.
- States: IDLE, SHIFT.
  - Start is accepted only in IDLE; start while in SHIFT is ignored (no queueing).
  - Start is accepted in the same cycle that done is high.
- Opcodes:
  - 0001 ADDC: A+B+cin.
  - 0010 ADD: A+B.
  - 0011 SUB: A-B; cout=1 when no borrow (A≥B unsigned).
  - 0100 AND.
  - 0101 NOR.
  - 0110 XNOR.
  - 0111 NOT A.
  - 1000 LSR.
  - 1001 LSL.
  - 1010 ASR.
  - 1011 ACC: acc<=acc+A; alu_out=new acc; cout/of from that add.
  - 1100 CLRACC: acc<=0; alu_out=0.
  - All others: alu_out=0, cout=0, of=0, done still pulses.
- Flags:
  - of is defined for ADDC/ADD/SUB/ACC only: two's-complement overflow of the WIDTH-bit result.
  - Logic ops force cout=0 and of=0.
  - zero and neg are always derived from the registered alu_out.
- Single-cycle ops: start sampled at edge N; alu_out/flags valid and done=1 after edge N; busy stays 0.
- Shift ops:
  - Distance k = min(aluin_b, WIDTH).
  - Edge N captures A and performs the first 1-bit shift when k≥1.
  - Each subsequent edge shifts 1 bit; busy=1 between start and completion.
  - done pulses after edge N+max(k,1)-1, i.e. latency max(k,1) cycles.
  - k=0: alu_out=A, cout=0, latency 1.
  - cout = last bit shifted out; of=0.
  - LSR/LSL fill with 0; ASR fills with the sign bit.
  - k=WIDTH: LSR/LSL give 0; ASR gives all sign bits.
- Intermediate shift values are held in an internal register. alu_out changes only when done pulses.
- Reset mid-shift: abort immediately to the reset state; the partial result is discarded.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADDC … OP_CLRACC) and the state encoding.
- One sub-module, alu_addsub: WIDTH-bit combinational adder/subtractor (sub selects B inversion with carry-in 1), outputs sum, cout, of. It is shared by ADD/ADDC/SUB/ACC.

Test Plan:
- WIDTH=8, ADD, A=0x7F, B=0x01 -> one cycle later done=1, alu_out=0x80, of=1, cout=0, neg=1, zero=0, busy never high.
- SUB, A=0x05, B=0x07 -> alu_out=0xFE, cout=0, of=0, neg=1; then SUB A=0x07, B=0x07 -> alu_out=0x00, cout=1, zero=1.
- LSR, A=0x0E, B=2 -> busy high, done after 2 cycles, alu_out=0x03, cout=1; start pulsed mid-shift with ADD is ignored (no extra done).
- ASR, A=0x90, B=12 -> clamps to 8, done after 8 cycles, alu_out=0xFF; LSL A=0x5A, B=0 -> done after 1 cycle, alu_out=0x5A, cout=0.
- ACC A=0x60 three times -> 0x60 (of=0), 0xC0 (of=1), 0x20 (cout=1); CLRACC -> 0x00, zero=1.
- Start LSR A=0xF0, B=6, assert reset after 3 cycles -> immediately busy=0, done=0, alu_out=0, zero=1; a following ADD 0x01+0x01 -> 0x02 normally.
